uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter_pkg.sv | 7 +
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 73 +++++++
 tb/tb_uart_tx_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_pkg: shared types and limits for the UART transmit arbiter
package uart_tx_pkg;
  typedef enum logic {IDLE, WAIT} state_t;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int N_CH_MIN = 2;
  localparam int N_CH_MAX = 8;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester channels plus multi-byte sender handshake
interface uart_tx_arbiter_if #(
  parameter int N_CH = 4,
  parameter int DATA_WIDTH = uart_tx_pkg::DATA_WIDTH_DEF
);
  localparam int IW = $clog2(N_CH);
  logic [N_CH-1:0] ch_req;
  logic [N_CH*DATA_WIDTH-1:0] ch_data;
  logic [N_CH-1:0] ch_busy;
  logic [N_CH-1:0] ch_done;
  logic [N_CH-1:0] ch_err;
  logic mb_send_en;
  logic [DATA_WIDTH-1:0] mb_data;
  logic mb_tx_done;
  logic [IW-1:0] active_ch;
  logic active;
  modport master(
    output ch_req, ch_data, mb_tx_done,
    input ch_busy, ch_done, ch_err, mb_send_en, mb_data, active_ch, active
  );
  modport slave(
    input ch_req, ch_data, mb_tx_done,
    output ch_busy, ch_done, ch_err, mb_send_en, mb_data, active_ch, active
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: first pending index at or above rr_ptr, wrapping modulo N_CH
module rr_pick #(
  parameter int N_CH = 4,
  localparam int IW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] pending,
  input  logic [IW-1:0]   rr_ptr,
  output logic            grant_valid,
  output logic [IW-1:0]   grant_idx
);
  logic [IW-1:0] j;
  // scan from the farthest offset down so the nearest pending index wins last
  always_comb begin
    grant_valid = 1'b0;
    grant_idx = '0;
    j = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      j = IW'((int'(rr_ptr) + k) % N_CH);
      if (pending[j]) begin
        grant_valid = 1'b1;
        grant_idx = j;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one multi-byte UART sender among N_CH requesters
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TIMEOUT = 1_000_000
) (
  input logic clk,
  input logic rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_CH);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t state;
  logic [N_CH-1:0] pending;
  logic [DATA_WIDTH-1:0] hold [N_CH];
  logic [IW-1:0] rr_ptr;
  logic [CW-1:0] cnt;
  logic grant_valid;
  logic [IW-1:0] grant_idx;
  logic [N_CH-1:0] accept;
  logic [N_CH-1:0] finish;
  logic done_hit;
  logic to_hit;
  rr_pick #(.N_CH(N_CH)) u_pick (
    .pending(pending),
    .rr_ptr(rr_ptr),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx)
  );
  assign accept = bus.ch_req & ~pending;
  assign done_hit = state == WAIT && bus.mb_tx_done;
  assign to_hit = state == WAIT && !bus.mb_tx_done && TIMEOUT != 0 && cnt == TLAST;
  assign finish = (done_hit || to_hit) ? N_CH'(1) << bus.active_ch : '0;
  assign bus.ch_busy = pending;
  assign bus.active = state == WAIT;
  // latch a channel's word only when it is not already holding one
  always_ff @(posedge clk)
    for (int i = 0; i < N_CH; i++)
      if (accept[i]) hold[i] <= bus.ch_data[i*DATA_WIDTH +: DATA_WIDTH];
  // grant/wait sequencer with completion and timeout reporting
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pending <= '0;
      rr_ptr <= '0;
      cnt <= '0;
      bus.mb_send_en <= 1'b0;
      bus.mb_data <= '0;
      bus.active_ch <= '0;
      bus.ch_done <= '0;
      bus.ch_err <= '0;
    end else begin
      pending <= (pending | accept) & ~finish;
      bus.ch_done <= done_hit ? finish : '0;
      bus.ch_err <= to_hit ? finish : '0;
      bus.mb_send_en <= 1'b0;
      if (state == IDLE && grant_valid) begin
        state <= WAIT;
        bus.mb_data <= hold[grant_idx];
        bus.mb_send_en <= 1'b1;
        bus.active_ch <= grant_idx;
        rr_ptr <= grant_idx == IW'(N_CH - 1) ? '0 : grant_idx + 1'b1;
        cnt <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt == CMAX ? cnt : cnt + 1'b1;
        if (done_hit || to_hit) state <= IDLE;
      end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: two arbiters (long and short timeout) checked against a behavioural model
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int TA = 64;
  localparam int TB = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] data = '0;
  logic txd[2] = '{1'b0, 1'b0};
  int lat[2] = '{40, 40};
  int k_rem[2] = '{0, 0};
  int tmo[2] = '{TA, TB};
  int n_chk = 0;
  int n_pass = 0;
  int se_cnt[2];
  int dn_cnt[2][N];
  int er_cnt[2][N];
  logic o_se[2], o_act[2];
  logic [N-1:0] o_busy[2], o_dn[2], o_er[2];
  logic [W-1:0] o_md[2];
  logic [1:0] o_ach[2];
  logic [N-1:0] m_pend[2];
  logic [W-1:0] m_hold[2][N];
  logic m_wait[2];
  logic [1:0] m_g[2], m_rr[2];
  int m_sent[2];
  logic e_se[2];
  logic [N-1:0] e_dn[2], e_er[2];
  logic [W-1:0] e_md[2];
  uart_tx_arbiter_if #(.N_CH(N), .DATA_WIDTH(W)) if_a ();
  uart_tx_arbiter_if #(.N_CH(N), .DATA_WIDTH(W)) if_b ();
  uart_tx_arbiter #(.N_CH(N), .DATA_WIDTH(W), .TIMEOUT(TA)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  uart_tx_arbiter #(.N_CH(N), .DATA_WIDTH(W), .TIMEOUT(TB)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  assign if_a.ch_req = req;
  assign if_a.ch_data = data;
  assign if_a.mb_tx_done = txd[0];
  assign if_b.ch_req = req;
  assign if_b.ch_data = data;
  assign if_b.mb_tx_done = txd[1];
  assign o_se[0] = if_a.mb_send_en;
  assign o_se[1] = if_b.mb_send_en;
  assign o_act[0] = if_a.active;
  assign o_act[1] = if_b.active;
  assign o_busy[0] = if_a.ch_busy;
  assign o_busy[1] = if_b.ch_busy;
  assign o_dn[0] = if_a.ch_done;
  assign o_dn[1] = if_b.ch_done;
  assign o_er[0] = if_a.ch_err;
  assign o_er[1] = if_b.ch_err;
  assign o_md[0] = if_a.mb_data;
  assign o_md[1] = if_b.mb_data;
  assign o_ach[0] = if_a.active_ch;
  assign o_ach[1] = if_b.active_ch;

  always #5 clk = ~clk;

  // cycle number, valid from just after each rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // sender stand-in: completion pulse lat cycles after each start pulse (lat 0 = never)
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      txd[i] = 1'b0;
      if (k_rem[i] > 0) begin
        k_rem[i]--;
        if (k_rem[i] == 0) txd[i] = 1'b1;
      end
      if (o_se[i]) k_rem[i] = lat[i];
    end
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  task automatic m_reset(input int i);
    m_pend[i] = '0;
    m_wait[i] = 1'b0;
    m_g[i] = '0;
    m_rr[i] = '0;
    e_se[i] = 1'b0;
    e_dn[i] = '0;
    e_er[i] = '0;
    e_md[i] = '0;
  endtask

  // advance the model by one cycle using the inputs seen in the current cycle
  task automatic m_step(input int i);
    logic [N-1:0] old;
    logic [N-1:0] nd;
    logic [N-1:0] ne;
    logic nse;
    logic [1:0] j;
    old = m_pend[i];
    nd = '0;
    ne = '0;
    nse = 1'b0;
    if (m_wait[i]) begin
      if (txd[i]) begin
        nd[m_g[i]] = 1'b1;
        m_pend[i][m_g[i]] = 1'b0;
        m_wait[i] = 1'b0;
      end else if (tmo[i] != 0 && cyc - m_sent[i] == tmo[i] - 1) begin
        ne[m_g[i]] = 1'b1;
        m_pend[i][m_g[i]] = 1'b0;
        m_wait[i] = 1'b0;
      end
    end else if (old != '0) begin
      for (int k = 0; k < N; k++) begin
        j = m_rr[i] + 2'(k);
        if (!nse && old[j]) begin
          m_g[i] = j;
          nse = 1'b1;
        end
      end
      e_md[i] = m_hold[i][m_g[i]];
      m_rr[i] = m_g[i] + 2'd1;
      m_sent[i] = cyc + 1;
      m_wait[i] = 1'b1;
    end
    for (int c = 0; c < N; c++)
      if (req[c] && !old[c]) begin
        m_hold[i][c] = data[c*W +: W];
        m_pend[i][c] = 1'b1;
      end
    e_se[i] = nse;
    e_dn[i] = nd;
    e_er[i] = ne;
  endtask

  task automatic compare(input int i);
    chk($sformatf("send_en[%0d]", i), o_se[i], e_se[i]);
    chk($sformatf("busy[%0d]", i), o_busy[i], m_pend[i]);
    chk($sformatf("done[%0d]", i), o_dn[i], e_dn[i]);
    chk($sformatf("err[%0d]", i), o_er[i], e_er[i]);
    chk($sformatf("mb_data[%0d]", i), o_md[i], e_md[i]);
    chk($sformatf("active_ch[%0d]", i), o_ach[i], m_g[i]);
    chk($sformatf("active[%0d]", i), o_act[i], m_wait[i]);
  endtask

  // per-cycle comparison against the model, mid-cycle away from the rising edge
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      if (rst) m_reset(i);
      compare(i);
      se_cnt[i] += int'(o_se[i]);
      for (int c = 0; c < N; c++) begin
        dn_cnt[i][c] += int'(o_dn[i][c]);
        er_cnt[i][c] += int'(o_er[i][c]);
      end
      if (!rst) m_step(i);
    end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // kind 0: start pulse, 1: done pulse on ch, 2: error pulse on ch
  task automatic wait_ev(input int i, input int kind, input int ch, input int bound, output int at);
    at = -1;
    for (int t = 0; t < bound && at < 0; t++) begin
      @(negedge clk);
      if (kind == 0 ? o_se[i] : kind == 1 ? o_dn[i][ch] : o_er[i][ch]) at = cyc;
    end
    if (at < 0) begin
      n_chk++;
      $display("FAIL wait inst%0d kind%0d ch%0d: no event within %0d cycles", i, kind, ch, bound);
    end
  endtask

  function automatic int sum_ev(input int i);
    int s;
    s = se_cnt[i];
    for (int c = 0; c < N; c++) s += dn_cnt[i][c] + er_cnt[i][c];
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, s, t, d, prev, base0, base1;
    tick(3);
    chk("reset_busy", o_busy[0], 0);
    chk("reset_send_en", o_se[0], 0);
    rst = 1'b0;
    // single request on ch2; short-timeout instance drops it and ignores the late done
    data[2*W +: W] = 32'hDEADBEEF;
    req = 4'b0100;
    n = cyc;
    tick(1);
    req = '0;
    wait_ev(0, 0, 0, 10, s);
    chk("t1_latency", 64'(s - n), 2);
    chk("t1_data", o_md[0], 32'hDEADBEEF);
    chk("t1_ach", o_ach[0], 2);
    wait_ev(1, 2, 2, 30, t);
    chk("t1_err_at", 64'(t - s), 16);
    wait_ev(0, 1, 2, 60, d);
    chk("t1_done_at", 64'(d - s), 41);
    chk("t1_busy_low", o_busy[0][2], 0);
    tick(5);
    chk("t1_late_done_ignored", dn_cnt[1][2], 0);
    // reset to bring rr_ptr back to 0, then all four request together
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int c = 0; c < N; c++) data[c*W +: W] = 32'hA000_0000 + c;
    req = 4'hF;
    tick(1);
    req = '0;
    prev = 0;
    for (int k = 0; k < N; k++) begin
      wait_ev(0, 0, 0, 60, s);
      chk("t2_order", o_ach[0], k);
      chk("t2_data", o_md[0], 32'hA000_0000 + k);
      if (k > 0) chk("t2_gap", 64'(s - prev), 42);
      prev = s;
    end
    wait_ev(0, 1, 3, 60, d);
    // fairness: ch0 re-requests on its done cycle while ch3 waits
    data[0 +: W] = 32'h0000_00F0;
    req = 4'b0001;
    tick(1);
    req = '0;
    wait_ev(0, 0, 0, 10, s);
    chk("t3_first", o_ach[0], 0);
    tick(1);
    data[3*W +: W] = 32'h0000_0033;
    req = 4'b1000;
    tick(1);
    req = '0;
    while (cyc < s + 41) tick(1);
    chk("t3_ch0_free", o_busy[0][0], 0);
    data[0 +: W] = 32'h0000_00F1;
    req = 4'b0001;
    tick(1);
    req = '0;
    wait_ev(0, 0, 0, 60, t);
    chk("t3_ch3_next", o_ach[0], 3);
    chk("t3_ch3_at", 64'(t - s), 42);
    wait_ev(0, 0, 0, 60, t);
    chk("t3_ch0_again", o_ach[0], 0);
    chk("t3_ch0_data", o_md[0], 32'h0000_00F1);
    wait_ev(0, 1, 0, 60, d);
    // a request while busy is dropped
    base0 = dn_cnt[0][1];
    data[W +: W] = 32'h1111_1111;
    req = 4'b0010;
    tick(1);
    data[W +: W] = 32'h2222_2222;
    tick(1);
    req = '0;
    wait_ev(0, 0, 0, 10, s);
    chk("t4_data", o_md[0], 32'h1111_1111);
    wait_ev(0, 1, 1, 60, d);
    tick(50);
    chk("t4_one_done", 64'(dn_cnt[0][1] - base0), 1);
    // completion on the same cycle as the timeout: done wins
    lat[1] = 15;
    data[2*W +: W] = 32'h5555_5555;
    req = 4'b0100;
    tick(1);
    req = '0;
    wait_ev(1, 0, 0, 10, s);
    base1 = er_cnt[1][2];
    wait_ev(1, 1, 2, 30, d);
    chk("t5_done_at", 64'(d - s), 16);
    tick(3);
    chk("t5_no_err", 64'(er_cnt[1][2] - base1), 0);
    wait_ev(0, 1, 2, 60, d);
    // asynchronous reset in the middle of a transfer
    data[W +: W] = 32'h7777_7777;
    req = 4'b0010;
    tick(1);
    req = '0;
    wait_ev(0, 0, 0, 10, s);
    tick(5);
    chk("t6_active_before", o_act[0], 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_active", o_act[0], 0);
    chk("t6_ach", o_ach[0], 0);
    chk("t6_busy_a", o_busy[0], 0);
    chk("t6_busy_b", o_busy[1], 0);
    chk("t6_mb_data", o_md[0], 0);
    tick(2);
    rst = 1'b0;
    base0 = sum_ev(0);
    base1 = sum_ev(1);
    tick(60);
    chk("t6_quiet_a", 64'(sum_ev(0) - base0), 0);
    chk("t6_quiet_b", 64'(sum_ev(1) - base1), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
